// File: rtl/fetch_unit_if.sv
// rtl/fetch_unit_if.sv - memory bus, decoder and control handshake bundle for fetch_unit
interface fetch_unit_if;
  logic [15:0] mem_addr;
  logic        mem_rd;
  logic        mem_ack;
  logic [7:0]  mem_rdata;
  logic        op_valid;
  logic [7:0]  opcode;
  logic        op_ready;
  logic        imm_req;
  logic        imm_valid;
  logic [7:0]  imm_data;
  logic        jump;
  logic [15:0] jump_addr;
  logic [15:0] pc;

  // fetch_unit side: drives the bus request and the decoder/control results
  modport master (
    output mem_addr, mem_rd, op_valid, opcode, imm_valid, imm_data, pc,
    input  mem_ack, mem_rdata, op_ready, imm_req, jump, jump_addr
  );

  // memory and control side
  modport slave (
    input  mem_addr, mem_rd, op_valid, opcode, imm_valid, imm_data, pc,
    output mem_ack, mem_rdata, op_ready, imm_req, jump, jump_addr
  );
endinterface

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - SM83 instruction byte fetcher owning the program counter
module fetch_unit #(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input logic          clk,
  input logic          rst_n,
  fetch_unit_if.master bus
);

  typedef enum logic [2:0] {
    BOOT  = 3'd0,
    FETCH = 3'd1,
    OPC   = 3'd2,
    IMM   = 3'd3,
    IMMV  = 3'd4
  } state_t;

  state_t      state;
  logic [15:0] pc_q;
  logic [7:0]  opcode_q;
  logic [7:0]  imm_q;

  // Sequencer: byte captures advance the PC on the same edge; OPC resolves jump > imm_req > op_ready
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= BOOT;
      pc_q     <= RESET_PC;
      opcode_q <= 8'h00;
      imm_q    <= 8'h00;
    end else begin
      case (state)
        BOOT: state <= FETCH;
        FETCH: begin
          if (bus.mem_ack) begin
            opcode_q <= bus.mem_rdata;
            pc_q     <= pc_q + 16'd1;
            state    <= OPC;
          end
        end
        OPC: begin
          if (bus.jump) begin
            pc_q  <= bus.jump_addr;
            state <= FETCH;
          end else if (bus.imm_req) begin
            state <= IMM;
          end else if (bus.op_ready) begin
            state <= FETCH;
          end
        end
        IMM: begin
          if (bus.mem_ack) begin
            imm_q <= bus.mem_rdata;
            pc_q  <= pc_q + 16'd1;
            state <= IMMV;
          end
        end
        IMMV: state <= OPC;
        default: state <= BOOT;
      endcase
    end
  end

  // Handshake outputs are pure decodes of the state register, so they never glitch on inputs
  assign bus.mem_addr  = pc_q;
  assign bus.pc        = pc_q;
  assign bus.mem_rd    = (state == FETCH) || (state == IMM);
  assign bus.op_valid  = (state == OPC) || (state == IMM) || (state == IMMV);
  assign bus.imm_valid = (state == IMMV);
  assign bus.opcode    = opcode_q;
  assign bus.imm_data  = imm_q;

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-byte supplier for the SM83 core. It sits between the memory bus and the opcode decoder and owns the program counter. It fetches opcode bytes and drives the decoder's `en`/`opcode` inputs. It also fetches immediate operand bytes on request from the control sequencer, and redirects the PC on jumps and `rst` vectors.

## Interface

Parameters:
- `RESET_PC`, default 16'h0000: PC value loaded on reset.

Ports:
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `mem_addr`  out  16  read address; always equals `pc`.
- `mem_rd`  out  1  read request; high in FETCH and IMM only.
- `mem_ack`  in  1  read data valid; sampled only while `mem_rd` is high.
- `mem_rdata`  in  8  read data; captured on the edge where `mem_rd && mem_ack`.
- `op_valid`  out  1  `opcode` is valid; drives decoder `en`.
- `opcode`  out  8  latched opcode byte.
- `op_ready`  in  1  control has finished with the current opcode.
- `imm_req`  in  1  control requests the next byte as an immediate.
- `imm_valid`  out  1  single-cycle strobe: `imm_data` is valid.
- `imm_data`  out  8  latched immediate byte.
- `jump`  in  1  load the PC from `jump_addr` (used for rst vectors and jumps).
- `jump_addr`  in  16  redirect target (e.g. the decoder's `reset_vec`).
- `pc`  out  16  current PC, which is the address of the next byte to fetch.

## Operation

- States: BOOT, FETCH, OPC, IMM, IMMV. The state is held in a registered state register; `mem_rd`, `op_valid` and `imm_valid` decode directly from the state.
- Reset (`rst_n` low at an edge):
  - state becomes BOOT; `pc` becomes `RESET_PC`; `opcode` and `imm_data` become 8'h00.
  - Resulting outputs: `mem_rd`=0, `op_valid`=0, `imm_valid`=0.
  - Reset overrides every other input, including `mem_ack` for an in-flight read.
- BOOT: unconditionally goes to FETCH on the next edge.
- FETCH: `mem_rd`=1.
  - On `mem_ack`: `opcode` ← `mem_rdata`, `pc` ← `pc`+1, go to OPC.
  - Otherwise: hold state, with `mem_addr` stable.
- OPC: `op_valid`=1. Priority is `jump` > `imm_req` > `op_ready`:
  - `jump`: `pc` ← `jump_addr`, go to FETCH. `op_valid` drops on the next cycle.
  - `imm_req`: go to IMM.
  - `op_ready`: go to FETCH.
  - None of these: hold.
- IMM: `mem_rd`=1 and `op_valid`=1; `opcode` is unchanged.
  - On `mem_ack`: `imm_data` ← `mem_rdata`, `pc` ← `pc`+1, go to IMMV.
- IMMV: `imm_valid`=1 and `op_valid`=1 for exactly one cycle, then return to OPC.
  - Control may chain a second `imm_req` from OPC (for 16-bit immediates).
- Inputs ignored by state:
  - `jump`, `imm_req` and `op_ready` are ignored in BOOT, FETCH, IMM and IMMV.
  - Control must hold them until OPC; a bench assertion flags `jump` outside OPC.
- PC arithmetic: 16-bit modulo, so 16'hFFFF+1 = 16'h0000 with no flag.
- `opcode` changes only on a FETCH capture. `imm_data` changes only on an IMM capture. Both hold their values across all other states.
- `mem_ack` while `mem_rd`=0 is ignored.

## Timing

- Registered outputs (state, `pc`, `opcode`, `imm_data`) change only at clock edges. `mem_addr` is a wire of `pc`.
- Memory handshake:
  - `mem_ack` may rise in the same cycle `mem_rd` rises, giving zero wait states.
  - Each wait state adds one cycle.
  - `mem_addr` is stable for the whole time `mem_rd` is high.
- Reset release (first edge with `rst_n`=1 is E0):
  - E0: BOOT→FETCH; `mem_rd` goes high after E0.
  - E1, with zero-wait ack: opcode captured; `op_valid` goes high after E1.
- Opcode latency: from FETCH entry to `op_valid` is 1 cycle plus wait states.
- `op_ready` sampled at edge En gives FETCH in cycle n+1, so `op_valid` is low for at least 1 cycle between opcodes.
- Immediate latency: from `imm_req` sampled in OPC to `imm_valid` is 2 cycles plus wait states.
- `pc` is incremented on the same edge as the byte capture.

## Test plan

- Reset with zero-wait memory holding [0000]=3E, [0001]=42:
  - `op_valid` rises 2 edges after release with `opcode`=3E and `pc`=0001.
  - `imm_req` leads to `imm_valid` pulsing for 1 cycle with `imm_data`=42 and `pc`=0002.
  - Then `op_ready` leads to FETCH at 0002.
- Wait states, with `mem_ack` delayed 3 cycles on the fetch at 0000:
  - `mem_rd` is high for 4 cycles with `mem_addr`=0000 stable.
  - `op_valid` stays low until after the ack edge.
- Jump: `opcode`=DF fetched from 0100, then `jump`=1 with `jump_addr`=0018 in OPC.
  - Next cycle: FETCH with `mem_addr`=0018 and `op_valid`=0.
- Wrap: with `RESET_PC`=FFFF, the fetch returns 00, leaving `pc`=0000.
  - A subsequent `imm_req` reads address 0000.
- Priority:
  - `jump`, `imm_req` and `op_ready` all high in OPC: the jump is taken and no IMM read occurs.
  - `imm_req` and `op_ready` together: the IMM read occurs and `opcode` is retained.
- Reset mid-IMM (awaiting ack), with `rst_n` low for 1 edge while `mem_ack`=1:
  - `mem_rd`=0, `op_valid`=0, `imm_valid`=0, `pc`=`RESET_PC`, and `imm_data`=00.
  - The stray `mem_ack` after reset has no effect.
